// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction prefetcher with a credit-limited request
// channel, an in-order response path and a FIFO_DEPTH-entry queue to decode.
// A redirect flushes the queue and marks every request still in flight as
// stale so that its response is dropped.
module if_prefetch_unit #(
  parameter logic [29:0] RST_PC_VAL = 30'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        jmp_en,
  input  logic [29:0] jmp_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [29:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [29:0] dec_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_CW  = CW'(FIFO_DEPTH);

  // Control state
  logic          r_run;
  logic [29:0]   r_fetch_pc;
  logic [29:0]   r_resp_pc;
  logic [CW-1:0] r_out;      // requests accepted but not yet answered
  logic [CW-1:0] r_stale;    // responses still to be discarded after a redirect
  logic [CW-1:0] r_wptr;     // extra MSB distinguishes full from empty
  logic [CW-1:0] r_rptr;

  // Queue storage (not reset; validity comes from the pointers)
  logic [31:0]   r_q_inst [FIFO_DEPTH];
  logic [29:0]   r_q_pc   [FIFO_DEPTH];

  logic [CW-1:0] w_occ;
  logic [CW:0]   w_credit;
  logic          w_fire;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_next;

  assign w_occ      = r_wptr - r_rptr;
  // O + occupancy can reach 2*FIFO_DEPTH in width terms, so sum one bit wider
  assign w_credit   = {1'b0, r_out} + {1'b0, w_occ};
  assign mem_req_valid = r_run && (w_credit < DEPTH_EXT);
  assign mem_req_addr  = r_fetch_pc;
  assign w_fire     = mem_req_valid && mem_req_ready;
  // A redirect discards both the coincident response and any coincident pop
  assign w_push     = mem_resp_valid && !jmp_en && (r_stale == '0);
  assign w_pop      = dec_valid && dec_ready && !jmp_en;
  assign w_out_next = r_out + CW'(w_fire) - CW'(mem_resp_valid);

  assign dec_valid  = (w_occ != '0);
  assign dec_inst   = r_q_inst[r_rptr[AW-1:0]];
  assign dec_pc     = r_q_pc[r_rptr[AW-1:0]];

  // Fetch/response sequencing, stale tracking and queue pointers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RST_PC_VAL;
      r_resp_pc  <= RST_PC_VAL;
      r_out      <= '0;
      r_stale    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_run <= 1'b1;
      r_out <= w_out_next;
      if (jmp_en) begin
        r_fetch_pc <= jmp_addr;
        r_resp_pc  <= jmp_addr;
        // Everything still in flight after this edge belongs to the old path
        r_stale    <= w_out_next;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + 30'd1;
        end
        if (mem_resp_valid && (r_stale != '0)) begin
          r_stale <= r_stale - CW'(1);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 30'd1;
          r_wptr    <= r_wptr + CW'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + CW'(1);
        end
      end
    end
  end

  // Queue write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_inst[r_wptr[AW-1:0]] <= mem_resp_data;
      r_q_pc[r_wptr[AW-1:0]]   <= r_resp_pc;
    end
  end

  // The credit rule must make a push into a full queue impossible
  assert property (@(posedge clk) disable iff (!rst_l) !(w_push && (w_occ == DEPTH_CW)));

endmodule

// File: tb/tb_if_prefetch_unit.sv
// tb_if_prefetch_unit: randomized bench for if_prefetch_unit. A memory model
// answers requests in order with variable latency; a transaction-level model
// tags requests with a redirect epoch and predicts the decode stream.
module tb_if_prefetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [29:0] RST   = 30'h100;

  logic        clk;
  logic        rst_l;
  logic        jmp_en;
  logic [29:0] jmp_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [29:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [29:0] dec_pc;

  if_prefetch_unit #(.RST_PC_VAL(RST), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_l(rst_l), .jmp_en(jmp_en), .jmp_addr(jmp_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [29:0] pc;
    logic [31:0] inst;
  } ent_t;

  req_t        memq[$];     // requests accepted by memory, answered in order
  ent_t        mq[$];       // instructions decode should see, in order
  logic [29:0] popped[$];   // PCs consumed by decode
  logic [29:0] exp_addr;    // address the next request must carry
  int          epoch;
  bit          m_run;
  int          cyc;
  int          fires;
  int          lat_min;
  int          lat_max;
  int          resp_pct;
  int          n_checks;
  int          n_fail;

  function automatic logic [31:0] mem_word(logic [29:0] a);
    return {a, 2'b01} ^ 32'h9E37_79B9;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance model
  task automatic step(input bit jmp, input logic [29:0] ja, input bit rdy, input bit drdy);
    bit   exp_rv;
    bit   fire;
    bit   rv;
    req_t e;
    exp_rv = m_run && ((memq.size() + mq.size()) < DEPTH);
    n_checks++;
    if (mem_req_valid !== exp_rv) begin
      n_fail++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, mem_req_valid, exp_rv);
    end
    n_checks++;
    if (mem_req_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, mem_req_addr, exp_addr);
    end
    n_checks++;
    if (dec_valid !== (mq.size() != 0)) begin
      n_fail++;
      $display("FAIL dec_valid cyc=%0d: got %b expected %b", cyc, dec_valid, mq.size() != 0);
    end
    if (mq.size() != 0) begin
      n_checks++;
      if (dec_pc !== mq[0].pc || dec_inst !== mq[0].inst) begin
        n_fail++;
        $display("FAIL dec_head cyc=%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                 cyc, dec_pc, dec_inst, mq[0].pc, mq[0].inst);
      end
    end

    rv = (memq.size() != 0) && (memq[0].due <= cyc) && ($urandom_range(99, 0) < resp_pct);
    jmp_en         = jmp;
    jmp_addr       = ja;
    mem_req_ready  = rdy;
    dec_ready      = drdy;
    mem_resp_valid = rv;
    mem_resp_data  = rv ? mem_word(memq[0].addr) : $urandom;
    fire = exp_rv && rdy;

    if (mq.size() != 0 && drdy && !jmp) begin
      popped.push_back(mq[0].pc);
      void'(mq.pop_front());
    end
    if (rv) begin
      e = memq.pop_front();
      if (!jmp && e.epoch == epoch) mq.push_back('{e.addr, mem_word(e.addr)});
    end
    if (fire) begin
      memq.push_back('{exp_addr, epoch, cyc + $urandom_range(lat_max, lat_min)});
      fires++;
    end
    if (jmp) begin
      mq.delete();
      epoch++;
      exp_addr = ja;
    end else if (fire) begin
      exp_addr = exp_addr + 30'd1;
    end
    m_run = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    jmp_en = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  // Hold reset for two cycles with memory and model cleared, release at negedge
  task automatic apply_reset();
    rst_l = 1'b0;
    jmp_en = 1'b0; jmp_addr = '0; mem_req_ready = 1'b0; dec_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    memq.delete(); mq.delete(); popped.delete();
    exp_addr = RST; m_run = 1'b0; epoch = 0; fires = 0;
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    jmp_en = 1'b0; jmp_addr = '0; mem_req_ready = 1'b1; dec_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (mem_req_valid !== 1'b0 || dec_valid !== 1'b0 || mem_req_addr !== RST) begin
      n_fail++;
      $display("FAIL reset_state: got rv=%b dv=%b addr=%h expected 0 0 %h",
               mem_req_valid, dec_valid, mem_req_addr, RST);
    end
    apply_reset();
    $display("test_reset done");
  endtask

  task automatic test_stream();
    int          k;
    logic [29:0] ev;
    apply_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    k = 0;
    while (dec_valid !== 1'b1 && k < 10) begin
      step(1'b0, '0, 1'b1, 1'b1);
      k++;
    end
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL first_dec_latency: got %0d cycles expected 3", k);
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ev = RST + 30'(i);
      n_checks++;
      if (i >= popped.size()) begin
        n_fail++;
        $display("FAIL stream_pc[%0d]: got nothing expected %h", i, ev);
      end else if (popped[i] !== ev) begin
        n_fail++;
        $display("FAIL stream_pc[%0d]: got %h expected %h", i, popped[i], ev);
      end
    end
    $display("test_stream done: %0d instructions consumed", popped.size());
  endtask

  task automatic test_backpressure();
    apply_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    repeat (12) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (fires != DEPTH || mem_req_valid !== 1'b0 || dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stall: got fires=%0d rv=%b dv=%b expected %0d 0 1",
               fires, mem_req_valid, dec_valid, DEPTH);
    end
    step(1'b0, '0, 1'b1, 1'b1);
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (fires != DEPTH + 1 || popped.size() != 1) begin
      n_fail++;
      $display("FAIL one_pop_one_req: got fires=%0d pops=%0d expected %0d 1",
               fires, popped.size(), DEPTH + 1);
    end
    $display("test_backpressure done: fires=%0d", fires);
  endtask

  task automatic test_jump();
    apply_reset();
    lat_min = 6; lat_max = 6; resp_pct = 100;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 30'h20, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (memq.size() != 3 || mem_req_addr !== 30'h23) begin
      n_fail++;
      $display("FAIL jump_setup: got inflight=%0d addr=%h expected 3 23", memq.size(), mem_req_addr);
    end
    popped.delete();
    step(1'b1, 30'h80, 1'b0, 1'b1);
    n_checks++;
    if (mem_req_addr !== 30'h80 || dec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL jump_redirect: got addr=%h dv=%b expected 80 0", mem_req_addr, dec_valid);
    end
    repeat (25) step(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (popped.size() == 0 || popped[0] !== 30'h80) begin
      n_fail++;
      $display("FAIL jump_first_pc: got %h expected 80", popped.size() ? popped[0] : 30'h0);
    end
    $display("test_jump done: %0d instructions after redirect", popped.size());
  endtask

  task automatic test_jump_coincident();
    logic [29:0] ev;
    bit          ok;
    apply_reset();
    lat_min = 1; lat_max = 1; resp_pct = 100;
    repeat (8) step(1'b0, '0, 1'b1, 1'b1);
    popped.delete();
    n_checks++;
    if (mem_req_valid !== 1'b1 || memq.size() == 0) begin
      n_fail++;
      $display("FAIL coincident_setup: got rv=%b inflight=%0d expected 1 >0", mem_req_valid, memq.size());
    end
    step(1'b1, 30'h300, 1'b1, 1'b1);
    repeat (15) step(1'b0, '0, 1'b1, $urandom_range(1, 0));
    ok = (popped.size() != 0);
    for (int i = 0; i < popped.size(); i++) begin
      ev = 30'h300 + 30'(i);
      if (popped[i] !== ev) ok = 1'b0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL coincident_no_stale: got first=%h count=%0d expected 300.. contiguous",
               popped.size() ? popped[0] : 30'h0, popped.size());
    end
    $display("test_jump_coincident done: %0d clean instructions", popped.size());
  endtask

  task automatic test_wrap();
    logic [29:0] ev;
    lat_min = 1; lat_max = 3; resp_pct = 100;
    step(1'b1, 30'h3FFFFFFE, 1'b1, 1'b1);
    popped.delete();
    repeat (20) step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ev = 30'h3FFFFFFE + 30'(i);
      n_checks++;
      if (i >= popped.size() || popped[i] !== ev) begin
        n_fail++;
        $display("FAIL wrap_pc[%0d]: got %h expected %h", i, (i < popped.size()) ? popped[i] : 30'h0, ev);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    bit          j;
    logic [29:0] ja;
    lat_min = 1; lat_max = 6; resp_pct = 70;
    for (int i = 0; i < 2000; i++) begin
      j  = ($urandom_range(99, 0) < 5);
      ja = $urandom_range(1, 0) ? (30'h3FFFFFF8 + 30'($urandom_range(7, 0))) : 30'($urandom);
      step(j, ja, $urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0);
    end
    $display("test_random done: %0d consumed", popped.size());
  endtask

  task automatic test_reset_mid();
    lat_min = 1; lat_max = 2; resp_pct = 100;
    repeat (12) step(1'b0, '0, 1'b1, 1'b0);
    n_checks++;
    if (dec_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_full: got dv=%b expected 1", dec_valid);
    end
    #2 rst_l = 1'b0;
    #1;
    n_checks++;
    if (dec_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got dv=%b rv=%b expected 0 0", dec_valid, mem_req_valid);
    end
    @(negedge clk);
    apply_reset();
    step(1'b0, '0, 1'b1, 1'b1);
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== RST) begin
      n_fail++;
      $display("FAIL restart: got rv=%b addr=%h expected 1 %h", mem_req_valid, mem_req_addr, RST);
    end
    repeat (10) step(1'b0, '0, 1'b1, 1'b1);
    $display("test_reset_mid done");
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; epoch = 0; fires = 0;
    lat_min = 1; lat_max = 1; resp_pct = 100;
    exp_addr = RST; m_run = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_jump_coincident();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parameterised successor to the single-register fetch stage. Generates word-aligned fetch addresses and issues them to instruction memory over a valid/ready request channel with variable, in-order response latency. Buffers returned instructions with their PCs in a FIFO_DEPTH-entry prefetch queue that feeds decode over a valid/ready handshake. Handles jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
RST_PC_VAL, 0, reset fetch word address (bits [31:2]).
FIFO_DEPTH, 4, prefetch queue entries and maximum outstanding plus buffered fetches; power of 2, >= 2.

Ports:
clk  in  1  clock, rising edge.
rst_l  in  1  asynchronous active-low reset.
jmp_en  in  1  redirect request, 1-cycle pulse.
jmp_addr  in  30  redirect target word address [31:2].
mem_req_valid  out  1  fetch request valid.
mem_req_ready  in  1  memory accepts request.
mem_req_addr  out  30  fetch word address [31:2].
mem_resp_valid  in  1  response data valid; in order, no backpressure.
mem_resp_data  in  32  fetched instruction.
dec_valid  out  1  queue head valid.
dec_ready  in  1  decode consumes head.
dec_inst  out  32  head instruction.
dec_pc  out  30  head word address [31:2].

Behaviour:
- clk is the only clock; rst_l is asynchronous, active-low. Reset state: fetch_pc=RST_PC_VAL, resp_pc=RST_PC_VAL, outstanding O=0, stale count D=0, queue empty, run=0. While rst_l is low, mem_req_valid=0 and dec_valid=0. run is set on the first clock edge after release.
- Credit rule: mem_req_valid = run && (O + occupancy < FIFO_DEPTH). mem_req_valid does not depend on jmp_en. mem_req_addr = fetch_pc.
- Request fire (valid && ready): O+1 and fetch_pc+1, mod 2^30 (wraps 0x3FFFFFFF -> 0).
- Response: O-1 on every mem_resp_valid.
  - If D>0: drop the response and decrement D.
  - Otherwise push {mem_resp_data, resp_pc} and increment resp_pc (mod 2^30).
- Queue: no bypass, so minimum latency is 1 cycle from response to dec_valid. Pop on dec_valid && dec_ready. Simultaneous push and pop leaves occupancy unchanged. The credit rule guarantees no overflow; a push when full is an assertion failure.
- Redirect (jmp_en=1), highest priority, same edge:
  - queue cleared; any pop in that cycle is ignored.
  - fetch_pc <= jmp_addr; resp_pc <= jmp_addr.
  - a response arriving that cycle is dropped.
  - D <= O + req_fire - resp_valid + ... i.e. all requests still in flight after this edge, including one accepted this cycle.
  - O is updated normally.
- Back-to-back redirects: each reloads D from the current in-flight count; earlier stale counts are subsumed.
- dec_valid, dec_inst and dec_pc are driven directly from the queue head register/array.
- Counter widths: O, D and occupancy are $clog2(FIFO_DEPTH)+1 bits.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests arriving afterwards are a system-level violation; memory must also be reset.

Test Plan:
1. Reset release, RST_PC_VAL=0x100, mem_req_ready=1, responses 1 cycle later, dec_ready=1 -> requests 0x100, 0x101, ...; dec_pc 0x100, 0x101, ... in order; first dec_valid 3 cycles after release.
2. dec_ready=0, FIFO_DEPTH=4 -> exactly 4 requests issued, then mem_req_valid=0 with 4 entries queued. dec_ready=1 for one cycle -> one pop, one new request.
3. Three requests in flight (0x20-0x22), jmp_en with jmp_addr=0x80 -> queue empties, next 3 responses dropped, mem_req_addr=0x80, first dec_pc=0x80.
4. jmp_en coincident with a request fire and a response -> D = in-flight count after the edge; the coincident response is not enqueued; no stale instruction ever reaches decode.
5. fetch_pc=0x3FFFFFFF -> next request address 0x00000000; dec_pc wraps identically.
6. rst_l pulsed low mid-stream with a full queue -> dec_valid and mem_req_valid go 0 asynchronously; fetch restarts at RST_PC_VAL.
